// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes, FSM states,
// and a byte-enable helper. Alignment checking is selected by MEM_STAGE_MISALIGN_CHK_EN.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Byte lanes touched by an access of the given size at an already-normalised lane offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_subword_align.sv
// Combinational lane extract (loads) and lane merge (sub-word stores) for little-endian words.
// MEM_STAGE_MISALIGN_CHK_EN enables misalignment detection; otherwise misaligned_o is tied 0.
module subword_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  logic [1:0]  lane_off;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [3:0]  byte_en;

  // Halves align down to addr[1], words ignore the low bits entirely.
  always_comb begin
    lane_off  = 2'b00;
    wdata_rep = wdata_i;
    case (mem_size_i)
      SZ_BYTE: begin
        lane_off  = byte_off_i;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_off  = {byte_off_i[1], 1'b0};
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = word_i >> {lane_off, 3'b000};
  assign byte_en = lane_mask(mem_size_i, lane_off);

  always_comb begin
    case (mem_size_i)
      SZ_BYTE: load_data_o = {{24{~mem_unsigned_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data_o = {{16{~mem_unsigned_i & shifted[15]}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_o[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : word_i[8*gi +: 8];
  end

`ifdef MEM_STAGE_MISALIGN_CHK_EN
  assign misaligned_o = (mem_size_i == SZ_HALF) ? byte_off_i[0] :
                        (mem_size_i[1]          ? (byte_off_i != 2'b00) : 1'b0);
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: zero-latency loads and word stores, two-cycle
// read-modify-write for byte/half stores. MEM_STAGE_MISALIGN_CHK_EN enables alignment traps.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int DM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign
);

  // Index split into the part that addresses the memory and the pass-through upper bits.
  localparam int AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  lsu_state_e      state_q, state_d;
  logic [31:0]     merged_q, merged_d;
  logic [AW-1:0]   idx_lo_q, idx_lo_d;
  logic [29-AW:0]  idx_hi_q, idx_hi_d;

  logic [31:0]     load_data;
  logic [31:0]     merged_word;
  logic            misaligned;
  logic            dm_we_c, stall_c;
  logic [31:0]     rdata_c;

  subword_align u_align (
    .mem_size_i     (mem_size),
    .mem_unsigned_i (mem_unsigned),
    .byte_off_i     (addr[1:0]),
    .word_i         (dm_rdata),
    .wdata_i        (wdata),
    .load_data_o    (load_data),
    .merged_o       (merged_word),
    .misaligned_o   (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    merged_d = merged_q;
    idx_lo_d = idx_lo_q;
    idx_hi_d = idx_hi_q;
    dm_we_c  = 1'b0;
    stall_c  = 1'b0;
    rdata_c  = 32'd0;
    dm_wdata = wdata;
    dm_addr  = {2'b00, addr[31:2]};
    case (state_q)
      IDLE: begin
        if (mem_req && !misaligned) begin
          if (!mem_we) begin
            rdata_c = load_data;
          end else if (mem_size[1]) begin
            dm_we_c = 1'b1;
          end else begin
            stall_c              = 1'b1;
            merged_d             = merged_word;
            {idx_hi_d, idx_lo_d} = addr[31:2];
            state_d              = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // Commit the merged word; the pipeline is released this cycle.
        dm_we_c  = 1'b1;
        dm_wdata = merged_q;
        dm_addr  = {2'b00, idx_hi_q, idx_lo_q};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      merged_q <= 32'd0;
      idx_lo_q <= '0;
      idx_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      idx_lo_q <= idx_lo_d;
      idx_hi_q <= idx_hi_d;
    end
  end

  // Reset masks the strobes immediately so an in-flight RMW write is dropped.
  assign dm_we    = dm_we_c & ~reset;
  assign stall    = stall_c & ~reset;
  assign rdata    = reset ? 32'd0 : rdata_c;
  assign misalign = misaligned & mem_req & (state_q == IDLE) & ~reset;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vectors then random traffic against
// a word-array reference model; honours MEM_STAGE_MISALIGN_CHK_EN when defined.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dm_rdata;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] dmem [128];
  logic [31:0] refm [128];

  mem_stage_lsu #(.DM_DEPTH(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .dm_rdata     (dm_rdata),
    .dm_addr      (dm_addr),
    .dm_we        (dm_we),
    .dm_wdata     (dm_wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign dm_rdata = dmem[dm_addr[6:0]];
  always @(posedge clk) if (dm_we) dmem[dm_addr[6:0]] <= dm_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_of(input logic [1:0] sz, input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'd1) o = (o / 2) * 2;
    else if (sz != 2'd0) o = 0;
    return o;
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] size_mask(input int n);
    return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
    int n;
    logic [31:0] m, v;
    n = nbytes(sz);
    m = size_mask(n);
    v = (word >> (8 * lane_of(sz, a))) & m;
    if (!uns && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] m;
    int sh;
    m  = size_mask(nbytes(sz));
    sh = 8 * lane_of(sz, a);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // One memory operation; covers both cycles of a read-modify-write store.
  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [6:0]  idx;
    logic [31:0] exp_addr, exp_word;
    bit          mis;
    idx      = a[8:2];
    exp_addr = {2'b00, a[31:2]};
    mis      = is_mis(sz, a);
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
    #1;
    $display("%s: we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h", tag, we, sz, uns, a, wd);
    chk({tag, " misalign"}, 32'(misalign), 32'(mis));
    if (mis) begin
      chk({tag, " mis dm_we"}, 32'(dm_we), 32'd0);
      chk({tag, " mis stall"}, 32'(stall), 32'd0);
      chk({tag, " mis rdata"}, rdata, 32'd0);
    end else if (!we) begin
      chk({tag, " rdata"}, rdata, model_load(refm[idx], sz, uns, a));
      chk({tag, " ld stall"}, 32'(stall), 32'd0);
      chk({tag, " ld dm_we"}, 32'(dm_we), 32'd0);
      chk({tag, " ld dm_addr"}, dm_addr, exp_addr);
    end else if (nbytes(sz) == 4) begin
      chk({tag, " sw dm_we"}, 32'(dm_we), 32'd1);
      chk({tag, " sw dm_wdata"}, dm_wdata, wd);
      chk({tag, " sw dm_addr"}, dm_addr, exp_addr);
      chk({tag, " sw stall"}, 32'(stall), 32'd0);
      refm[idx] = wd;
    end else begin
      exp_word = model_store(refm[idx], wd, sz, a);
      chk({tag, " rmw1 stall"}, 32'(stall), 32'd1);
      chk({tag, " rmw1 dm_we"}, 32'(dm_we), 32'd0);
      chk({tag, " rmw1 rdata"}, rdata, 32'd0);
      @(negedge clk);
      // Second cycle must ignore whatever the pipeline presents.
      mem_req = 1'($urandom_range(0, 1)); mem_we = 1'($urandom_range(0, 1));
      mem_size = 2'($urandom_range(0, 3)); mem_unsigned = 1'($urandom_range(0, 1));
      addr = $urandom; wdata = $urandom;
      #1;
      chk({tag, " rmw2 dm_we"}, 32'(dm_we), 32'd1);
      chk({tag, " rmw2 dm_wdata"}, dm_wdata, exp_word);
      chk({tag, " rmw2 dm_addr"}, dm_addr, exp_addr);
      chk({tag, " rmw2 stall"}, 32'(stall), 32'd0);
      chk({tag, " rmw2 rdata"}, rdata, 32'd0);
      chk({tag, " rmw2 misalign"}, 32'(misalign), 32'd0);
      refm[idx] = exp_word;
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 3));
    mem_unsigned = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
    #1;
    $display("%s: idle addr=0x%08h", tag, addr);
    chk({tag, " dm_we"}, 32'(dm_we), 32'd0);
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " rdata"}, rdata, 32'd0);
    chk({tag, " misalign"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_unsigned = 1'b0;
    addr = 32'h6; wdata = 32'hDEAD_BEEF;
    #12;
    $display("reset: outputs under reset");
    chk("reset dm_we", 32'(dm_we), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 128; i++) op(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "preload");

    op(1'b1, 2'd2, 1'b0, 32'h4, 32'h8899_AABB, "sw idx1");
    op(1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344, "sw idx2");
    op(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, "lb 0x4");
    op(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, "lbu 0x7");
    op(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, "lh 0x6");
    op(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, "lhu 0x4");
    op(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, "lw upper bits");
    op(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00EE, "sb 0x9");
    op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "lw after sb");
    op(1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344, "sw idx2 again");
    op(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_BEEF, "sh 0xA");
    op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "lw after sh");
    op(1'b1, 2'd0, 1'b0, 32'hC000_0009, 32'h0000_0077, "sb upper bits");
    op(1'b1, 2'd0, 1'b0, 32'h0, 32'h0000_0011, "sb b2b first");
    op(1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_0022, "sb b2b second");
    op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw after b2b");
    idle_cycle("idle");

    // Reset during RMW_WR must drop the write.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0000_0055;
    #1;
    $display("sb 0x0 with reset in RMW_WR");
    chk("abort rmw1 stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1; mem_req = 1'b0;
    #1;
    chk("abort dm_we", 32'(dm_we), 32'd0);
    chk("abort stall", 32'(stall), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("abort idle dm_we", 32'(dm_we), 32'd0);
    op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw word0 after abort");

    op(1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFE_F00D, "sw 0x6");
    op(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, "lw idx1 after sw 0x6");
    op(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000_1234, "sh 0x3");
    op(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, "lh 0x5");
    op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "lw reserved size");

    for (int i = 0; i < 250; i++) begin
      r = $urandom;
      if (i % 10 == 9) idle_cycle("rand idle");
      else op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              r & 32'hC000_01FF, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
